// File: rtl/div_multicycle_if.sv
// Divide request/response bundle between the execute stage (master) and the
// multicycle divider (slave).
interface div_multicycle_if;
  logic        valid;
  logic        ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [63:0] c;

  modport master (output valid, ready, a, b, input done, c);
  modport slave  (input valid, ready, a, b, output done, c);
endinterface

// File: rtl/div_multicycle.sv
// Unsigned 32/32 radix-2 restoring divider, STEPS_PER_CYCLE quotient bits per
// cycle. The result is {remainder, quotient}, held while the requester stalls.
module div_multicycle #(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  div_multicycle_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] STEP = 6'(STEPS_PER_CYCLE);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, dq_q, div_q;
  logic [31:0] rem_n, dq_n;
  logic [32:0] sh, trial;
  logic [63:0] c_q;
  logic        done_q;
  logic        last;

  assign last     = (cnt_q + STEP) == 6'd32;
  assign bus.done = done_q;
  assign bus.c    = c_q;

  // The shifted-out remainder MSB is kept as bit 32 of the trial, so a
  // partial remainder that briefly exceeds 32 bits still compares correctly.
  always_comb begin
    // NOTE: blocking assignments here chain the steps within one cycle; each
    // iteration sees the previous iteration's rem_n/dq_n.
    rem_n = rem_q;
    dq_n  = dq_q;
    sh    = '0;
    trial = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      sh    = {rem_n, dq_n[31]};
      dq_n  = {dq_n[30:0], 1'b0};
      trial = sh - {1'b0, div_q};
      if (!trial[32]) begin
        rem_n   = trial[31:0];
        dq_n[0] = 1'b1;
      end else begin
        rem_n = sh[31:0];
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.valid) state_d = RUN;
      RUN: begin
        if (!bus.valid) state_d = IDLE;
        else if (last)  state_d = DONE;
      end
      DONE: begin
        // Dropping valid takes priority over ready.
        if (!bus.valid)     state_d = IDLE;
        else if (bus.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (bus.valid) begin
            dq_q  <= bus.a;
            div_q <= bus.b;
            rem_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          // An abort leaves c untouched; the datapath is reloaded on accept.
          if (bus.valid) begin
            rem_q <= rem_n;
            dq_q  <= dq_n;
            cnt_q <= cnt_q + STEP;
            if (last) c_q <= {rem_n, dq_n};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_multicycle.md
# div_multicycle

Multicycle unsigned 32/32 radix-2 restoring divider. It is the responder side of the execute stage's `valid`/`done` divide handshake. The execute stage presents magnitudes, holds `valid` high, and stalls while `valid && ~done`. It applies sign correction to the returned `{remainder, quotient}` itself. The block adds a `ready` input, so a stalled pipeline that keeps `valid` high never restarts a finished divide.

## Interface
- `STEPS_PER_CYCLE`, default 1: quotient bits resolved per cycle. Legal values are 1, 2, 4. Run length is N = 32/STEPS_PER_CYCLE cycles.
- `clk  in  1`: clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `valid  in  1`: divide requested. Held high by the requester until the result is consumed. Deassertion aborts the operation.
- `ready  in  1`: requester advances this cycle, i.e. the execute stage is not stalled. Only sampled in DONE.
- `a  in  32`: dividend magnitude. Sampled on the accept edge only.
- `b  in  32`: divisor magnitude. Sampled on the accept edge only.
- `done  out  1`: result valid. Registered; equals `state==DONE`.
- `c  out  64`: result, `{remainder[31:0], quotient[31:0]}`. Registered; stable throughout DONE.

## Operation
- **States:** IDLE, RUN, DONE. A 6-bit iteration counter `cnt`.
- **IDLE:**
  - `valid=1` → latch `a` into the dividend/quotient shift register and `b` into the divisor register; clear the partial remainder; `cnt←0`; go to RUN.
  - Otherwise stay in IDLE.
- **RUN, per cycle:** perform STEPS_PER_CYCLE chained restoring steps. One step is:
  - shift {rem, dq} left by 1;
  - trial = rem − divisor, computed 33 bits wide;
  - if trial is non-negative: rem←trial[31:0] and dq[0]←1;
  - else dq[0]←0.
  - Then `cnt←cnt+STEPS_PER_CYCLE`.
- **RUN exit:** when `cnt+STEPS_PER_CYCLE==32`, write `c←{rem_next, dq_next}` and go to DONE.
- **RUN abort:** `valid=0` → IDLE. `c` is left unchanged and `done` stays 0.
- **DONE:** `done=1`.
  - `valid=1, ready=0` → stay in DONE; hold `c`.
  - `valid=1, ready=1` → IDLE (result consumed).
  - `valid=0` → IDLE.
- **Divide by zero:** no special path. The natural algorithm result is required: quotient=0xFFFFFFFF, remainder=a.
- **Width rules:** the remainder is kept 32 bits plus a 33-bit compare. No overflow is possible for unsigned operands.
- **Reset:** state=IDLE, `cnt=0`, `done=0`, `c=0`, all datapath registers 0. This holds from any state, including mid-RUN.

## Timing
- Accept edge E0: IDLE with `valid=1`.
- RUN occupies the N cycles after E0.
- `done` is first high in cycle N+1 after E0. With STEPS_PER_CYCLE=1 this is cycle 33, i.e. the requester sees 33 stall cycles.
- `c` changes only on the RUN→DONE edge or on reset.
- Back-to-back divides: DONE with `valid=1, ready=1` at edge Ek → IDLE. The next divide is accepted at edge Ek+1 if `valid` is still high. That is one bubble cycle between operations.
- `ready` is ignored in IDLE and RUN.
- `a` and `b` may change after E0 without effect.
- `valid` low in DONE takes priority over `ready`.
- Reset has priority over every transition.

## Test plan
- **Basic divide:** STEPS_PER_CYCLE=1, a=100, b=7, `valid` held, `ready=1` → `done` rises exactly 33 cycles after accept; `c=0x00000002_0000000E`; `done` falls the next cycle.
- **Divide by zero and identity:**
  - a=0x12345678, b=0 → `c=0x12345678_FFFFFFFF`.
  - a=0xFFFFFFFF, b=1 → `c=0x00000000_FFFFFFFF`.
  - a=5, b=9 → `c=0x00000005_00000000`.
- **Stall hold:** a=1000, b=3, `ready=0` for 4 cycles after `done` → `done` stays 1 and `c=0x00000001_0000014D` is stable. `ready=1` → IDLE, and a new op (a=9, b=2) starts the following cycle with result `0x00000001_00000004`.
- **Abort:** drop `valid` at RUN cycle 10 → IDLE next cycle with `done=0` and `c` unchanged. Re-asserting `valid` starts a fresh 33-cycle op.
- **Mid-RUN reset:** assert `reset` at RUN cycle 20 → next cycle `done=0`, `c=0`, state IDLE. After reset, a=100, b=7 gives the correct result.
- **Parameter sweep:** STEPS_PER_CYCLE=2 and 4, 1000 random operand pairs including b=0 → `done` latency is 17 and 9 cycles respectively; quotient = a/b and remainder = a%b against the reference model.
